// File: rtl/clock_set_controller.sv
// Mode/set sequencer for the clock display: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
// Optional hold-to-repeat on the increment button is enabled with `define CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_controller #(
    parameter int BLINK_CYCLES   = 25_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    input  logic       inc_level,
    output logic       run_enable,
    output logic [1:0] sel_field,
    output logic       inc_hours,
    output logic       inc_minutes,
    output logic       clr_seconds,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic            run_enable_q, run_enable_d;
    logic [1:0]      sel_field_q, sel_field_d;
    logic            inc_hours_q, inc_hours_d;
    logic            inc_minutes_q, inc_minutes_d;
    logic            clr_seconds_q, clr_seconds_d;
    logic            blink_q, blink_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            inc_fire;
    logic            auto_fire;
    logic            strobe;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          repeating_q, repeating_d;
    logic          fired_q, fired_d;

    // A press that already produced auto-repeat strobes must not count again on release.
    assign inc_fire = inc_pulse & ~fired_q;

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        repeating_d = repeating_q;
        auto_fire   = 1'b0;
        if (mode_pulse || !inc_level || !(state_q == SET_HR || state_q == SET_MIN)) begin
            hold_cnt_d  = '0;
            rpt_cnt_d   = '0;
            repeating_d = 1'b0;
        end else if (!repeating_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                auto_fire   = 1'b1;
                repeating_d = 1'b1;
                hold_cnt_d  = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end else if (rpt_cnt_q == RPT_LAST) begin
            auto_fire = 1'b1;
            rpt_cnt_d = '0;
        end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
    end
`else
    localparam int unused_auto_cycles = HOLD_CYCLES + REPEAT_CYCLES;
    logic unused_inc_level;
    assign unused_inc_level = inc_level;
    assign inc_fire         = inc_pulse;
    assign auto_fire        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_d       = blink_q;
        inc_hours_d   = 1'b0;
        inc_minutes_d = 1'b0;
        clr_seconds_d = 1'b0;
        strobe        = inc_fire | auto_fire;

        if (mode_pulse) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_SEC;
                default: state_d = RUN;
            endcase
        end else if (state_q != RUN) begin
            inc_hours_d   = strobe && (state_q == SET_HR);
            inc_minutes_d = strobe && (state_q == SET_MIN);
            clr_seconds_d = strobe && (state_q == SET_SEC);
            if (inc_pulse || auto_fire) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LAST) begin
                state_d = RUN;
            end else begin
                idle_cnt_d = idle_cnt_q + TW'(1);
            end
        end

        // Entering any state (or sitting in RUN) restarts the blink phase and idle timer.
        if (state_d != state_q || state_d == RUN) begin
            idle_cnt_d  = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        run_enable_d = (state_d == RUN);
        sel_field_d  = state_d;
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    always_comb begin
        fired_d = fired_q;
        if (auto_fire) begin
            fired_d = 1'b1;
        end else if (inc_pulse || mode_pulse || state_d != state_q) begin
            fired_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            run_enable_q  <= 1'b1;
            sel_field_q   <= 2'd0;
            inc_hours_q   <= 1'b0;
            inc_minutes_q <= 1'b0;
            clr_seconds_q <= 1'b0;
            blink_q       <= 1'b1;
            blink_cnt_q   <= '0;
            idle_cnt_q    <= '0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
            hold_cnt_q    <= '0;
            rpt_cnt_q     <= '0;
            repeating_q   <= 1'b0;
            fired_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            run_enable_q  <= run_enable_d;
            sel_field_q   <= sel_field_d;
            inc_hours_q   <= inc_hours_d;
            inc_minutes_q <= inc_minutes_d;
            clr_seconds_q <= clr_seconds_d;
            blink_q       <= blink_d;
            blink_cnt_q   <= blink_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
            hold_cnt_q    <= hold_cnt_d;
            rpt_cnt_q     <= rpt_cnt_d;
            repeating_q   <= repeating_d;
            fired_q       <= fired_d;
`endif
        end
    end

    assign run_enable  = run_enable_q;
    assign sel_field   = sel_field_q;
    assign inc_hours   = inc_hours_q;
    assign inc_minutes = inc_minutes_q;
    assign clr_seconds = clr_seconds_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller: a behavioural model queues the expected
// registered outputs for every driven cycle, and they are compared one cycle later.
module tb_clock_set_controller;

    localparam int BLINK   = 4;
    localparam int TIMEOUT = 20;
    localparam int HOLD    = 8;
    localparam int REPEAT  = 3;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_pulse = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       inc_level = 1'b0;
    logic       run_enable;
    logic [1:0] sel_field;
    logic       inc_hours;
    logic       inc_minutes;
    logic       clr_seconds;
    logic       blink;

    clock_set_controller #(
        .BLINK_CYCLES  (BLINK),
        .TIMEOUT_CYCLES(TIMEOUT),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_pulse (mode_pulse),
        .inc_pulse  (inc_pulse),
        .inc_level  (inc_level),
        .run_enable (run_enable),
        .sel_field  (sel_field),
        .inc_hours  (inc_hours),
        .inc_minutes(inc_minutes),
        .clr_seconds(clr_seconds),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run;
        logic [1:0] sel;
        logic       hr;
        logic       mn;
        logic       sc;
        logic       bl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_hr = 0;
    int   n_min = 0;
    int   n_sec = 0;
    int   cyc = 0;

    // Reference model state: cycles since entering the state, idle cycles, held cycles.
    int m_state = 0;
    int m_since = 0;
    int m_idle  = 0;
    int m_held  = 0;
    bit m_fired = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL cyc=%0d %s: got %0h expected %0h", cyc, tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic m, input logic i, input logic l);
        exp_t e;
        int   nstate;
        int   held_now;
        bit   autof;
        bit   changed;
        e = '0;
        if (r) begin
            m_state = 0; m_since = 0; m_idle = 0; m_held = 0; m_fired = 1'b0;
            e.run = 1'b1;
            e.bl  = 1'b1;
        end else begin
            nstate   = m_state;
            held_now = 0;
            if (AUTO && !m && l && (m_state == 1 || m_state == 2)) held_now = m_held + 1;
            autof = (held_now >= HOLD) && ((held_now - HOLD) % REPEAT == 0);
            if (m) begin
                nstate = (m_state + 1) % 4;
            end else if (m_state != 0) begin
                if ((i && !m_fired) || autof) begin
                    e.hr = (m_state == 1);
                    e.mn = (m_state == 2);
                    e.sc = (m_state == 3);
                end
                if (i || autof) m_idle = 0;
                else if (m_idle == TIMEOUT - 1) nstate = 0;
                else m_idle++;
            end
            changed = (nstate != m_state);
            if (changed || nstate == 0) begin
                m_since = 0;
                m_idle  = 0;
            end else begin
                m_since++;
            end
            if (autof) m_fired = 1'b1;
            else if (i || m || changed) m_fired = 1'b0;
            m_held  = changed ? 0 : held_now;
            m_state = nstate;
            e.run = (nstate == 0);
            e.sel = 2'(nstate);
            e.bl  = (nstate == 0) || ((m_since / BLINK) % 2 == 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_val("run_enable", 32'(run_enable), 32'(e.run));
        check_val("sel_field", 32'(sel_field), 32'(e.sel));
        check_val("inc_hours", 32'(inc_hours), 32'(e.hr));
        check_val("inc_minutes", 32'(inc_minutes), 32'(e.mn));
        check_val("clr_seconds", 32'(clr_seconds), 32'(e.sc));
        check_val("blink", 32'(blink), 32'(e.bl));
        if (inc_hours === 1'b1) n_hr++;
        if (inc_minutes === 1'b1) n_min++;
        if (clr_seconds === 1'b1) n_sec++;
        $display("cyc=%0d rst=%0b mode=%0b inc=%0b lvl=%0b -> run=%0b sel=%0d hr=%0b min=%0b sec=%0b blink=%0b",
                 cyc, rst, mode_pulse, inc_pulse, inc_level, run_enable, sel_field,
                 inc_hours, inc_minutes, clr_seconds, blink);
    endtask

    task automatic cycle(input logic r, input logic m, input logic i, input logic l);
        rst = r; mode_pulse = m; inc_pulse = i; inc_level = l;
        model_step(r, m, i, l);
        @(posedge clk);
        #1;
        cyc++;
        compare_out();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lvl;
        // Reset and idle in RUN.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        check_val("idle_run", 32'(run_enable), 32'd1);
        check_val("idle_sel", 32'(sel_field), 32'd0);

        // Walk through all four states.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            check_val("mode_sel", 32'(sel_field), 32'((i + 1) % 4));
            check_val("mode_run", 32'(run_enable), (i == 3) ? 32'd1 : 32'd0);
            idle(2);
        end

        // Three increments in SET_MIN, then return to RUN and try one there.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_hr = 0; n_min = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            check_val("min_strobe_now", 32'(inc_minutes), 32'd1);
            idle(1);
            check_val("min_strobe_gone", 32'(inc_minutes), 32'd0);
        end
        check_val("min_strobe_count", 32'(n_min), 32'd3);
        check_val("hr_strobe_count", 32'(n_hr), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_hr = 0; n_min = 0; n_sec = 0;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check_val("run_inc_ignored", 32'(n_hr + n_min + n_sec), 32'd0);

        // Mode and inc together in SET_HR: mode wins, inc dropped.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_hr = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("mode_wins_sel", 32'(sel_field), 32'd2);
        check_val("mode_wins_hr", 32'(n_hr), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Timeout from SET_HR after TIMEOUT idle cycles.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(TIMEOUT - 1);
        check_val("timeout_before", 32'(sel_field), 32'd1);
        idle(1);
        check_val("timeout_sel", 32'(sel_field), 32'd0);
        check_val("timeout_run", 32'(run_enable), 32'd1);

        // An inc at idle cycle 15 restarts the timeout.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(14);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(TIMEOUT - 1);
        check_val("restart_before", 32'(sel_field), 32'd1);
        idle(1);
        check_val("restart_sel", 32'(sel_field), 32'd0);

        // Reset mid-edit drops the pending strobe.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_hr = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("rst_edit_sel", 32'(sel_field), 32'd0);
        check_val("rst_edit_hr", 32'(n_hr), 32'd0);

        // Random traffic, model-checked every cycle.
        lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) lvl = ~lvl;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 5) == 0), lvl);
        end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
        // Hold inc for 15 cycles in SET_HR: strobes at held cycles 8, 11, 14; none at release.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_hr = 0;
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("auto_release_hr", 32'(inc_hours), 32'd0);
        idle(2);
        check_val("auto_hr_count", 32'(n_hr), 32'd3);
`endif

        idle(2);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
